// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared digit type, digit constants and display-owner states
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_BLANK = 4'hF;
  localparam digit_t DIGIT_MAX   = 4'd9;

  typedef enum logic {
    SHOW_CNT = 1'b0,
    SHOW_MSG = 1'b1
  } disp_state_t;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit 0..9 with increment, clear and carry-out
module bcd_digit
  import seg7_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   inc,
  output digit_t digit,
  output logic   carry
);

  // carry tells the next digit up that this one is rolling 9 -> 0
  assign carry = inc && (digit == DIGIT_MAX);

  // clear beats increment so a clear coincident with a step never leaks a carry into the count
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? digit_t'(0) : digit + 4'd1;
    end
  end

endmodule

// File: rtl/seg7_disp_ctrl.sv
// rtl/seg7_disp_ctrl.sv - BCD counter plus message arbiter for a two-digit display; SEG7_DISP_CTRL_LZB_EN enables leading-zero blanking
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       clear_in,
  input  logic       msg_req_in,
  input  logic [7:0] msg_val_in,
  output logic       msg_ack_out,
  output logic       msg_busy_out,
  output logic [7:0] count_out,
  output logic       wrap_out,
  output logic [3:0] seg7val_out [1:0]
);

  localparam int PW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam int HW = ($clog2(HOLD_CYCLES) > 0) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

  logic          run_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          step;
  digit_t        ones;
  digit_t        tens;
  logic          ones_carry;
  logic          tens_carry;
  logic          wrap_q;

  disp_state_t   state_q;
  disp_state_t   state_d;
  logic          accept;
  logic [HW-1:0] timer_q;
  digit_t        msg_tens_q;
  digit_t        msg_ones_q;
  digit_t        cnt_tens_q;
  digit_t        cnt_ones_q;
  logic          ack_q;

  assign tick  = run_q && (presc_q == PRESC_LAST);
  // a clear in the tick cycle swallows the step, so neither digit moves and no wrap is reported
  assign step  = tick && !clear_in;

  // run flag: stop has priority over start
  always_ff @(posedge clk) begin
    if (reset || stop_in) begin
      run_q <= 1'b0;
    end else if (start_in) begin
      run_q <= 1'b1;
    end
  end

  // prescaler runs 0..TICK_DIV-1 only while running and freezes when stopped
  always_ff @(posedge clk) begin
    if (reset || clear_in) begin
      presc_q <= '0;
    end else if (run_q) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  bcd_digit u_ones (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_in),
    .inc   (step),
    .digit (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_in),
    .inc   (ones_carry),
    .digit (tens),
    .carry (tens_carry)
  );

  // wrap is registered so it lines up with the edge where the count shows 00
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tens_carry;
    end
  end

  assign count_out = {tens, ones};
  assign wrap_out  = wrap_q;

  assign accept = (state_q == SHOW_CNT) && msg_req_in;

  // display owner state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW_CNT;
    end else begin
      state_q <= state_d;
    end
  end

  // next owner: a request takes the display, the hold timer hands it back
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_CNT: if (msg_req_in)       state_d = SHOW_MSG;
      SHOW_MSG: if (timer_q == '0)    state_d = SHOW_CNT;
      default:                        state_d = SHOW_CNT;
    endcase
  end

  // message latch, hold timer, ack pulse and the one-stage copy of the count
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      msg_tens_q <= '0;
      msg_ones_q <= '0;
      cnt_tens_q <= '0;
      cnt_ones_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        msg_tens_q <= msg_val_in[7:4];
        msg_ones_q <= msg_val_in[3:0];
        timer_q    <= HOLD_LOAD;
      end else if ((state_q == SHOW_MSG) && (timer_q != '0)) begin
        timer_q <= timer_q - 1'b1;
      end
`ifdef SEG7_DISP_CTRL_LZB_EN
      cnt_tens_q <= (tens == 4'd0) ? DIGIT_BLANK : tens;
`else
      cnt_tens_q <= tens;
`endif
      cnt_ones_q <= ones;
    end
  end

  assign msg_ack_out = ack_q;

  // outputs follow the current owner; message digits are never blanked
  always_comb begin
    msg_busy_out   = 1'b0;
    seg7val_out[1] = cnt_tens_q;
    seg7val_out[0] = cnt_ones_q;
    if (state_q == SHOW_MSG) begin
      msg_busy_out   = 1'b1;
      seg7val_out[1] = msg_tens_q;
      seg7val_out[0] = msg_ones_q;
    end
  end

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// tb/tb_seg7_disp_ctrl.sv - directed bench for seg7_disp_ctrl with TICK_DIV=4, HOLD_CYCLES=8
module tb_seg7_disp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_in;
  logic       stop_in;
  logic       clear_in;
  logic       msg_req_in;
  logic [7:0] msg_val_in;
  logic       msg_ack_out;
  logic       msg_busy_out;
  logic [7:0] count_out;
  logic       wrap_out;
  logic [3:0] seg7val_out [1:0];
  logic [7:0] disp;

`ifdef SEG7_DISP_CTRL_LZB_EN
  localparam logic [3:0] ZT = 4'hF;
`else
  localparam logic [3:0] ZT = 4'h0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int extra_acks  = 0;

  seg7_disp_ctrl #(
    .TICK_DIV    (4),
    .HOLD_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .clear_in     (clear_in),
    .msg_req_in   (msg_req_in),
    .msg_val_in   (msg_val_in),
    .msg_ack_out  (msg_ack_out),
    .msg_busy_out (msg_busy_out),
    .count_out    (count_out),
    .wrap_out     (wrap_out),
    .seg7val_out  (seg7val_out)
  );

  assign disp = {seg7val_out[1], seg7val_out[0]};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_in = 1'b0; stop_in = 1'b0; clear_in = 1'b0;
    msg_req_in = 1'b0; msg_val_in = 8'h00;
    step(3);
    reset = 1'b0;
    chk("rst_count", count_out, 8'h00);
    chk("rst_wrap", 8'(wrap_out), 8'h00);
    chk("rst_ack", 8'(msg_ack_out), 8'h00);
    chk("rst_busy", 8'(msg_busy_out), 8'h00);
    chk("rst_disp", disp, 8'h00);

    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    chk("start_count", count_out, 8'h00);
    step(3);
    chk("pre_tick", count_out, 8'h00);
    step(1);
    chk("first_tick", count_out, 8'h01);
    step(16);
    chk("count_05", count_out, 8'h05);
    step(1);
    chk("disp_05", disp, {ZT, 4'h5});
    step(18);
    chk("count_09", count_out, 8'h09);
    step(1);
    chk("count_10", count_out, 8'h10);
    chk("disp_lag", disp, {ZT, 4'h9});
    step(1);
    chk("disp_10", disp, 8'h10);

    step(355);
    chk("count_99", count_out, 8'h99);
    chk("wrap_idle", 8'(wrap_out), 8'h00);
    step(3);
    chk("pre_wrap", 8'(wrap_out), 8'h00);
    step(1);
    chk("wrap_count", count_out, 8'h00);
    chk("wrap_pulse", 8'(wrap_out), 8'h01);
    step(1);
    chk("wrap_end", 8'(wrap_out), 8'h00);

    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    start_in = 1'b1; stop_in = 1'b1;
    step(4);
    start_in = 1'b0; stop_in = 1'b0;
    step(8);
    chk("stop_wins", count_out, 8'h00);

    clear_in = 1'b1;
    step(1);
    clear_in = 1'b0;
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    chk("restart", count_out, 8'h00);
    step(180);
    chk("count_45", count_out, 8'h45);
    step(3);
    clear_in = 1'b1;
    step(1);
    clear_in = 1'b0;
    chk("clr_tick", count_out, 8'h00);
    chk("clr_nowrap", 8'(wrap_out), 8'h00);
    step(3);
    chk("clr_presc", count_out, 8'h00);
    step(1);
    chk("run_kept", count_out, 8'h01);

    msg_val_in = 8'hA7; msg_req_in = 1'b1;
    step(1);
    msg_req_in = 1'b0;
    chk("msg_ack", 8'(msg_ack_out), 8'h01);
    chk("msg_busy", 8'(msg_busy_out), 8'h01);
    chk("msg_disp", disp, 8'hA7);
    for (int i = 2; i <= 8; i++) begin
      step(1);
      chk("msg_ack_once", 8'(msg_ack_out), 8'h00);
      chk("msg_busy_hold", 8'(msg_busy_out), 8'h01);
      chk("msg_disp_hold", disp, 8'hA7);
    end
    chk("msg_bg_count", count_out, 8'h03);
    step(1);
    chk("msg_done_busy", 8'(msg_busy_out), 8'h00);
    chk("msg_done_disp", disp, {ZT, 4'h3});

    msg_val_in = 8'h3C; msg_req_in = 1'b1;
    step(1);
    chk("hold_ack1", 8'(msg_ack_out), 8'h01);
    chk("hold_disp1", disp, 8'h3C);
    msg_val_in = 8'h58;
    for (int i = 11; i <= 17; i++) begin
      step(1);
      extra_acks += int'(msg_ack_out);
      chk("hold_busy", 8'(msg_busy_out), 8'h01);
      chk("hold_latched", disp, 8'h3C);
    end
    chk("hold_one_ack", 8'(extra_acks), 8'h00);
    step(1);
    chk("gap_busy", 8'(msg_busy_out), 8'h00);
    chk("gap_ack", 8'(msg_ack_out), 8'h00);
    step(1);
    msg_req_in = 1'b0;
    chk("second_ack", 8'(msg_ack_out), 8'h01);
    chk("second_busy", 8'(msg_busy_out), 8'h01);
    chk("second_disp", disp, 8'h58);
    step(9);
    chk("idle_busy", 8'(msg_busy_out), 8'h00);
    chk("idle_ack", 8'(msg_ack_out), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
